// File: rtl/core_scheduler.sv
// rtl/core_scheduler.sv - per-core instruction-step FSM owning the shared current_pc
// Optional feature: define SCHED_DIVERGENCE_CHECK_EN to stop the block on per-thread PC divergence.
module core_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8,
  parameter int TC_WIDTH          = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [TC_WIDTH-1:0]                   thread_count,
  input  logic                                  fetch_ready,
  input  logic                                  decoded_mem_rw,
  input  logic                                  decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]        lsu_state,
  input  logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                            core_state,
  output logic [PC_WIDTH-1:0]                   current_pc,
  output logic                                  done,
  output logic                                  pc_diverged
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic                done_next;
  logic                lsu_busy;

  // Only threads below thread_count can hold the core in WAIT.
  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if ((TC_WIDTH'(i) < thread_count) &&
          (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10))
        lsu_busy = 1'b1;
    end
  end

`ifdef SCHED_DIVERGENCE_CHECK_EN
  logic diverged_q, diverged_next;
  logic pc_mismatch;
  logic unused_inputs;

  assign unused_inputs = decoded_mem_rw;

  always_comb begin
    pc_mismatch = 1'b0;
    for (int i = 1; i < THREADS_PER_BLOCK; i++) begin
      if ((TC_WIDTH'(i) < thread_count) &&
          (next_pc[PC_WIDTH*i +: PC_WIDTH] != next_pc[PC_WIDTH-1:0]))
        pc_mismatch = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) diverged_q <= 1'b0;
    else        diverged_q <= diverged_next;
  end

  assign pc_diverged = diverged_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{decoded_mem_rw, next_pc[PC_WIDTH*THREADS_PER_BLOCK-1:PC_WIDTH]};
  assign pc_diverged   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      current_pc <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      current_pc <= pc_next;
      done       <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = current_pc;
    done_next  = done;
`ifdef SCHED_DIVERGENCE_CHECK_EN
    diverged_next = diverged_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
        end
      end
      S_FETCH:   if (fetch_ready) state_next = S_DECODE;
      S_DECODE:  state_next = S_REQUEST;
      S_REQUEST: state_next = S_WAIT;
      S_WAIT:    if (!lsu_busy) state_next = S_EXECUTE;
      S_EXECUTE: state_next = S_UPDATE;
      S_UPDATE: begin
        if (decoded_ret) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end
`ifdef SCHED_DIVERGENCE_CHECK_EN
        else if (pc_mismatch) begin
          state_next    = S_DONE;
          done_next     = 1'b1;
          diverged_next = 1'b1;
        end
`endif
        else begin
          pc_next    = next_pc[PC_WIDTH-1:0];
          state_next = S_FETCH;
        end
      end
      S_DONE:  done_next = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  assign core_state = state;

endmodule

// File: tb/tb_core_scheduler.sv
// tb/tb_core_scheduler.sv - self-checking bench for core_scheduler (honours SCHED_DIVERGENCE_CHECK_EN)
module tb_core_scheduler;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_REQUEST = 3'd3,
                         ST_WAIT = 3'd4, ST_EXECUTE = 3'd5, ST_UPDATE = 3'd6, ST_DONE = 3'd7;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  thread_count = 3'd4;
  logic        fetch_ready = 1'b0;
  logic        decoded_mem_rw = 1'b0;
  logic        decoded_ret = 1'b0;
  logic [7:0]  lsu_state = 8'h00;
  logic [31:0] next_pc = 32'h0;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        done;
  logic        pc_diverged;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [31:0] npc;
    logic [2:0]  tc;
    logic        ret;
    logic [7:0]  exp_pc;
    logic [2:0]  exp_state;
    logic        exp_div;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [2:0] st;
    logic       div;
  } exp_t;

  vec_t vecs[5];
  exp_t exp_q[$];

  core_scheduler dut (
    .clock(clock), .reset(reset), .start(start), .thread_count(thread_count),
    .fetch_ready(fetch_ready), .decoded_mem_rw(decoded_mem_rw), .decoded_ret(decoded_ret),
    .lsu_state(lsu_state), .next_pc(next_pc), .core_state(core_state),
    .current_pc(current_pc), .done(done), .pc_diverged(pc_diverged)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset_start();
    reset = 1'b0;
    #1;
    check("rst_state", core_state, ST_IDLE);
    check("rst_pc", current_pc, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_div", pc_diverged, 1'b0);
    #1;
    reset = 1'b1;
    start = 1'b1;
    step();
    check("start_fetch", core_state, ST_FETCH);
    start = 1'b0;
  endtask

  // Drives one non-memory instruction from FETCH; the scoreboard entry is resolved on return to FETCH/DONE.
  task automatic run_instr(input vec_t v);
    exp_t e;
    int   n;
    next_pc        = v.npc;
    thread_count   = v.tc;
    decoded_ret    = v.ret;
    decoded_mem_rw = 1'b0;
    lsu_state      = 8'h00;
    check({v.name, "_at_fetch"}, core_state, ST_FETCH);
    e.name = v.name; e.pc = v.exp_pc; e.st = v.exp_state; e.div = v.exp_div;
    exp_q.push_back(e);
    fetch_ready = 1'b1;
    n = 0;
    do begin
      step();
      fetch_ready = 1'b0;
      n++;
    end while (core_state != ST_FETCH && core_state != ST_DONE && n < 40);
    e = exp_q.pop_front();
    check({e.name, "_latency"}, n, 6);
    check({e.name, "_state"}, core_state, e.st);
    check({e.name, "_pc"}, current_pc, e.pc);
    check({e.name, "_div"}, pc_diverged, e.div);
    check({e.name, "_done"}, done, e.st == ST_DONE);
    decoded_ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    vecs[0] = '{"add_05",   32'h05050505, 3'd4, 1'b0, 8'h05, ST_FETCH, 1'b0};
    vecs[1] = '{"tc1_ign",  32'h3333330A, 3'd1, 1'b0, 8'h0A, ST_FETCH, 1'b0};
    vecs[2] = '{"to_ff",    32'hFFFFFFFF, 3'd4, 1'b0, 8'hFF, ST_FETCH, 1'b0};
    vecs[3] = '{"wrap_00",  32'h00000000, 3'd4, 1'b0, 8'h00, ST_FETCH, 1'b0};
`ifdef SCHED_DIVERGENCE_CHECK_EN
    vecs[4] = '{"diverge",  32'h07090707, 3'd3, 1'b0, 8'h00, ST_DONE,  1'b1};
`else
    vecs[4] = '{"diverge",  32'h07090707, 3'd3, 1'b0, 8'h07, ST_FETCH, 1'b0};
`endif

    #3;
    do_reset_start();

    // fetch_ready arrives late: FETCH must hold
    for (int k = 0; k < 3; k++) begin
      step();
      check("fetch_hold", core_state, ST_FETCH);
    end

    for (int i = 0; i < 5; i++) run_instr(vecs[i]);

    // LDR: thread 2 stalls WAIT for 4 cycles (01,01,10,10), then reports 11
    do_reset_start();
    thread_count = 3'd4; decoded_mem_rw = 1'b1; next_pc = 32'h11111111;
    lsu_state = 8'b00_01_00_00;
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0;
    check("ldr_decode", core_state, ST_DECODE);
    step();
    check("ldr_request", core_state, ST_REQUEST);
    step();
    for (int k = 0; k < 4; k++) begin
      lsu_state = (k < 2) ? 8'b00_01_00_00 : 8'b00_10_00_00;
      check("ldr_wait_hold", core_state, ST_WAIT);
      step();
    end
    check("ldr_wait_last", core_state, ST_WAIT);
    lsu_state = 8'b00_11_00_00;
    step();
    check("ldr_execute", core_state, ST_EXECUTE);
    step();
    check("ldr_update", core_state, ST_UPDATE);
    step();
    check("ldr_fetch", core_state, ST_FETCH);
    check("ldr_pc", current_pc, 8'h11);

    // Inactive thread 3 stuck in WAIT must not stall a 3-thread block
    thread_count = 3'd3; lsu_state = 8'b10_11_11_11; next_pc = 32'h22222222;
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0;
    step(); step();
    check("inact_wait", core_state, ST_WAIT);
    step();
    check("inact_execute", core_state, ST_EXECUTE);
    step(); step();
    check("inact_pc", current_pc, 8'h22);
    decoded_mem_rw = 1'b0;

    // Async reset while stalled in WAIT
    thread_count = 3'd1; lsu_state = 8'b00_00_00_10;
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0;
    step(); step(); step();
    check("midwait_hold", core_state, ST_WAIT);
    do_reset_start();
    lsu_state = 8'h00;

    // RET ends the block; start is ignored in DONE
    r = '{"add_09", 32'h09090909, 3'd4, 1'b0, 8'h09, ST_FETCH, 1'b0};
    run_instr(r);
    r = '{"ret", 32'h44444444, 3'd4, 1'b1, 8'h09, ST_DONE, 1'b0};
    run_instr(r);
    for (int k = 0; k < 4; k++) begin
      start = k[0];
      step();
      check("done_state", core_state, ST_DONE);
      check("done_flag", done, 1'b1);
      check("done_pc", current_pc, 8'h09);
    end
    start = 1'b0;
    do_reset_start();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
